// File: rtl/shift_seq_ctrl_pkg.sv
// shift_seq_ctrl_pkg -- shared encodings for the shift sequencer.
//   Shifter op codes (drive shifter8.op), command op encodings, FSM
//   state encoding, and a small helper for the per-step shift amount.
package shift_seq_ctrl_pkg;

  // Shifter op codes
  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_LOAD = 3'b001;
  localparam logic [2:0] OP_LSL  = 3'b010;
  localparam logic [2:0] OP_LSR  = 3'b011;
  localparam logic [2:0] OP_ASR  = 3'b100;

  // Command op encodings
  typedef enum logic [1:0] {
    CMD_LSL  = 2'b00,
    CMD_LSR  = 2'b01,
    CMD_ASR  = 2'b10,
    CMD_RSVD = 2'b11
  } cmd_op_e;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_SHIFT = 3'd2,
    S_DONE  = 3'd3,
    S_ERR   = 3'd4
  } state_e;

  // Per-step shift distance: min(rem, 3)
  function automatic logic [1:0] step_amt(input logic [3:0] rem);
    return (rem > 4'd3) ? 2'd3 : rem[1:0];
  endfunction

  // Map a legal command op to the shifter op code
  function automatic logic [2:0] cmd_to_op(input logic [1:0] cmd);
    case (cmd)
      CMD_LSL: return OP_LSL;
      CMD_LSR: return OP_LSR;
      CMD_ASR: return OP_ASR;
      default: return OP_NOP;
    endcase
  endfunction

endpackage

// File: rtl/shift_seq_ctrl.sv
// shift_seq_ctrl -- breaks a 0..15 bit shift command into a LOAD step
// followed by up to five shift steps of at most 3 bits for shifter8.
// Ports:
//   clk, reset (async, active high)
//   start, abort, cmd_op[1:0], cmd_amt[3:0], cmd_data[7:0]  -- command in
//   op[2:0], shamt[1:0], d_in[7:0]                         -- shifter drive
//   busy, done, err                                         -- status
// All outputs decode registered state only (Moore).
module shift_seq_ctrl
  import shift_seq_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       abort,
  input  logic [1:0] cmd_op,
  input  logic [3:0] cmd_amt,
  input  logic [7:0] cmd_data,
  output logic [2:0] op,
  output logic [1:0] shamt,
  output logic [7:0] d_in,
  output logic       busy,
  output logic       done,
  output logic       err
);

  state_e     state_q, state_d;
  logic [2:0] sh_op_q, sh_op_d;
  logic [3:0] rem_q,   rem_d;
  logic [7:0] data_q,  data_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      sh_op_q <= OP_NOP;
      rem_q   <= 4'd0;
      data_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      sh_op_q <= sh_op_d;
      rem_q   <= rem_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sh_op_d = sh_op_q;
    rem_d   = rem_q;
    data_d  = data_q;
    case (state_q)
      S_IDLE: begin
        // abort outranks start; reserved ops capture nothing
        if (start && !abort) begin
          if (cmd_op == CMD_RSVD) begin
            state_d = S_ERR;
          end else begin
            sh_op_d = cmd_to_op(cmd_op);
            rem_d   = cmd_amt;
            data_d  = cmd_data;
            state_d = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        if (abort)              state_d = S_IDLE;
        else if (rem_q != 4'd0) state_d = S_SHIFT;
        else                    state_d = S_DONE;
      end
      S_SHIFT: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          // step_amt never exceeds rem, so this cannot wrap
          rem_d   = rem_q - {2'b00, step_amt(rem_q)};
          state_d = (rem_d != 4'd0) ? S_SHIFT : S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    op    = OP_NOP;
    shamt = 2'd0;
    case (state_q)
      S_LOAD:  op = OP_LOAD;
      S_SHIFT: begin
        op    = sh_op_q;
        shamt = step_amt(rem_q);
      end
      default: op = OP_NOP;
    endcase
  end

  assign d_in = data_q;
  assign busy = (state_q == S_LOAD) || (state_q == S_SHIFT);
  assign done = (state_q == S_DONE);
  assign err  = (state_q == S_ERR);

endmodule

// File: tb/tb_shift_seq_ctrl.sv
module tb_shift_seq_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       start, abort;
  logic [1:0] cmd_op;
  logic [3:0] cmd_amt;
  logic [7:0] cmd_data;
  logic [2:0] op;
  logic [1:0] shamt;
  logic [7:0] d_in;
  logic       busy, done, err;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  shift_seq_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .cmd_op(cmd_op), .cmd_amt(cmd_amt), .cmd_data(cmd_data),
    .op(op), .shamt(shamt), .d_in(d_in),
    .busy(busy), .done(done), .err(err)
  );

  // Behavioural stand-in for shifter8, driven by the DUT outputs
  logic [7:0] sh_q = 8'h00;
  always_ff @(posedge clk) begin
    case (op)
      3'b001: sh_q <= d_in;
      3'b010: sh_q <= sh_q << shamt;
      3'b011: sh_q <= sh_q >> shamt;
      3'b100: sh_q <= $unsigned($signed(sh_q) >>> shamt);
      default: sh_q <= sh_q;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] o, input logic [3:0] a, input logic [7:0] d);
    start    = 1'b1;
    cmd_op   = o;
    cmd_amt  = a;
    cmd_data = d;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_op"},   {29'd0, op},   32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_err"},  {31'd0, err},  32'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0;
    cmd_op = 2'd0; cmd_amt = 4'd0; cmd_data = 8'd0;
    #2;
    chk_quiet("rst");
    chk("rst_shamt", {30'd0, shamt}, 32'd0);
    chk("rst_din",   {24'd0, d_in},  32'd0);
    tick(); tick();
    reset = 1'b0;
    tick();
    chk_quiet("idle");

    // Load-only: amt 0
    issue(2'b00, 4'd0, 8'hA5);
    tick(); start = 1'b0;
    chk("lo_op",   {29'd0, op},   32'h1);
    chk("lo_din",  {24'd0, d_in}, 32'hA5);
    chk("lo_busy", {31'd0, busy}, 32'h1);
    tick();
    chk("lo_done", {31'd0, done}, 32'h1);
    chk("lo_dop",  {29'd0, op},   32'h0);
    chk("lo_dbsy", {31'd0, busy}, 32'h0);
    chk("lo_sh",   {24'd0, sh_q}, 32'hA5);
    tick();
    chk("lo_done2", {31'd0, done}, 32'h0);

    // Long left shift: amt 7 -> 3,3,1
    issue(2'b00, 4'd7, 8'h01);
    tick(); start = 1'b0;
    chk("lsl_load", {29'd0, op}, 32'h1);
    tick();
    chk("lsl_op1", {29'd0, op},    32'h2);
    chk("lsl_s1",  {30'd0, shamt}, 32'h3);
    tick();
    chk("lsl_s2",  {30'd0, shamt}, 32'h3);
    tick();
    chk("lsl_s3",  {30'd0, shamt}, 32'h1);
    chk("lsl_op3", {29'd0, op},    32'h2);
    tick();
    chk("lsl_done", {31'd0, done}, 32'h1);
    chk("lsl_sh",   {24'd0, sh_q}, 32'h80);
    tick();

    // Saturating ASR: amt 15 -> five steps of 3
    issue(2'b10, 4'd15, 8'h80);
    tick(); start = 1'b0;
    chk("asr_load", {29'd0, op}, 32'h1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("asr_op", {29'd0, op},    32'h4);
      chk("asr_s",  {30'd0, shamt}, 32'h3);
    end
    tick();
    chk("asr_done", {31'd0, done}, 32'h1);
    chk("asr_sh",   {24'd0, sh_q}, 32'hFF);
    tick();
    chk("asr_idle", {31'd0, done}, 32'h0);

    // Reserved op -> single err pulse
    issue(2'b11, 4'd5, 8'h33);
    tick(); start = 1'b0;
    chk("rsv_err",  {31'd0, err},  32'h1);
    chk("rsv_op",   {29'd0, op},   32'h0);
    chk("rsv_busy", {31'd0, busy}, 32'h0);
    tick();
    chk_quiet("rsv_after");

    // abort in IDLE outranks start
    issue(2'b11, 4'd1, 8'h11); abort = 1'b1;
    tick();
    chk("abi_err", {31'd0, err}, 32'h0);
    issue(2'b00, 4'd1, 8'h11);
    tick(); start = 1'b0; abort = 1'b0;
    chk("abi_busy", {31'd0, busy}, 32'h0);
    chk("abi_din",  {24'd0, d_in}, 32'h80);

    // Abort with start re-asserted while busy
    issue(2'b01, 4'd9, 8'hF0);
    tick();
    chk("ab_load", {29'd0, op},   32'h1);
    chk("ab_din",  {24'd0, d_in}, 32'hF0);
    issue(2'b00, 4'd2, 8'h55);
    tick();
    chk("ab_op",    {29'd0, op},    32'h3);
    chk("ab_shamt", {30'd0, shamt}, 32'h3);
    abort = 1'b1;
    tick(); start = 1'b0; abort = 1'b0;
    chk_quiet("ab_idle");
    chk("ab_sh", {24'd0, sh_q}, 32'h1E);
    tick();
    chk_quiet("ab_idle2");
    chk("ab_din2", {24'd0, d_in}, 32'hF0);

    // Async reset mid-SHIFT
    issue(2'b10, 4'd15, 8'h80);
    tick(); start = 1'b0;
    tick();
    chk("ar_busy", {31'd0, busy}, 32'h1);
    #3 reset = 1'b1;
    #1;
    chk_quiet("ar_rst");
    chk("ar_shamt", {30'd0, shamt}, 32'h0);
    chk("ar_din",   {24'd0, d_in},  32'h0);
    #2 reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_quiet("ar_post");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/shift_seq_ctrl.md
SHIFT_SEQ_CTRL -- requirements
Module: shift_seq_ctrl

Interface
REQ-001 Parameters: none; op codes and state encodings come from the shared package.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  command request; sampled only in IDLE.
REQ-005 abort  input  1  cancels a command in progress.
REQ-006 cmd_op  input  2  00 LSL, 01 LSR, 10 ASR, 11 reserved.
REQ-007 cmd_amt  input  4  total shift distance, 0..15.
REQ-008 cmd_data  input  8  operand to load into the shifter register.
REQ-009 op  output  3  shifter op: NOP 000, LOAD 001, LSL 010, LSR 011, ASR 100.
REQ-010 shamt  output  2  per-step shift amount for the shifter.
REQ-011 d_in  output  8  operand for the shifter; equals captured cmd_data.
REQ-012 busy  output  1  high in LOAD and SHIFT states.
REQ-013 done  output  1  one-cycle pulse on normal completion.
REQ-014 err  output  1  one-cycle pulse when a reserved cmd_op is rejected.

Function
REQ-015 States: IDLE, LOAD, SHIFT, DONE, ERR; all outputs are registered or decoded from the state register only (Moore), with no combinational path from any input to any output.
REQ-016 IDLE: op=NOP, shamt=0, busy=0, done=0, err=0.
REQ-017 IDLE with start=1, abort=0 and cmd_op!=11: capture cmd_op, cmd_amt and cmd_data, then enter LOAD.
REQ-018 IDLE with start=1, abort=0 and cmd_op=11: capture nothing, enter ERR.
REQ-019 ERR lasts exactly one cycle with err=1 and op=NOP, then returns to IDLE.
REQ-020 LOAD lasts exactly one cycle with op=LOAD and d_in=captured data.
REQ-021 From LOAD, enter SHIFT if the remaining count rem (initialised to cmd_amt) is nonzero; otherwise enter DONE.
REQ-022 Each SHIFT cycle: op=the captured shift code, shamt=min(rem,3), and rem is decremented by shamt at the clock edge.
REQ-023 SHIFT repeats while the decremented rem is nonzero; otherwise enter DONE.
REQ-024 Shift-cycle count is N=ceil(cmd_amt/3), so 0..5 cycles.
REQ-025 DONE lasts exactly one cycle with done=1 and op=NOP, then returns to IDLE.
REQ-026 Latency: start sampled at edge T gives LOAD in cycle T+1, shifts in cycles T+2..T+1+N, and done in cycle T+2+N.
REQ-027 start while busy=1 is ignored; a new start is first accepted in the DONE cycle's following IDLE cycle.
REQ-028 abort=1 in LOAD or SHIFT: enter IDLE at the next edge; no done pulse is issued, and op=NOP from that cycle on.
REQ-029 abort=1 in IDLE has priority over start: the command is not captured and no err pulse is issued.
REQ-030 abort in DONE or ERR has no effect; the pulse completes.
REQ-031 rem is 4 bits wide and never underflows, since shamt is always at most rem.

Reset
REQ-032 reset=1 forces IDLE immediately, independent of clk, and clears rem and all captured registers to 0.
REQ-033 While reset=1: op=NOP, shamt=0, d_in=0, busy=0, done=0, err=0.
REQ-034 Reset asserted mid-command discards the command; no done or err pulse is issued after release.

Structure
REQ-035 A shared package holds the op-code constants (NOP, LOAD, LSL, LSR, ASR), the cmd_op encodings and the state encoding.
REQ-036 The block has no sub-module; it drives the existing shifter8 (op, shamt, d_in) at the integration level.

Verification
REQ-037 Load-only: start with cmd_op=00, amt=0, data=8'hA5 -> LOAD cycle with d_in=A5, then DONE; paired shifter holds A5; done at T+2.
REQ-038 Long left shift: cmd_op=00, amt=7, data=8'h01 -> shamt sequence 3,3,1; shifter result 8'h80; done at T+5.
REQ-039 Saturating arithmetic shift: cmd_op=10, amt=15, data=8'h80 -> five SHIFT cycles of shamt 3; result FF; done at T+7.
REQ-040 Reserved op: start with cmd_op=11 -> single err pulse at T+1, op stays NOP, busy never asserts.
REQ-041 Abort and busy-start: cmd_op=01, amt=9, data=8'hF0, with start re-asserted during SHIFT and abort after the first SHIFT -> second start ignored; return to IDLE; no done pulse; shifter holds 8'h1E.
REQ-042 Asynchronous reset: assert reset mid-SHIFT between clock edges -> outputs go to their reset values immediately; after release the block idles with no stray pulses.
